// File: rtl/decode_operand_stage.sv
// decode_operand_stage: RV32I decode + operand fetch stage feeding the 32-bit ALU.
//
// One instruction is accepted per valid/ready handshake, decoded, its
// operands read from an internal 32x32 register file, and the resulting
// A / B / ALUSel bundle is registered for the ALU.  A separate writeback port
// updates the register file every cycle, independent of the handshake.
//
// Optional build macro:
//   DECODE_WB_BYPASS_EN  - when defined, a writeback landing in the accept
//                          cycle to rs1/rs2 is forwarded into the captured
//                          operand (write-first).  When undefined the
//                          pre-write value is captured (read-first) and the
//                          downstream hazard logic is expected to stall.
//   x0 is never bypassed in either build.

module decode_operand_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction input handshake
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    // register-file writeback port
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    // ALU-facing output handshake
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_A,
    output logic [XLEN-1:0] out_B,
    output logic [3:0]      out_ALUSel,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    // ALU operation select codes
    localparam logic [3:0] SEL_ADD    = 4'd0;
    localparam logic [3:0] SEL_SUB    = 4'd1;
    localparam logic [3:0] SEL_SLL    = 4'd2;
    localparam logic [3:0] SEL_SLT    = 4'd3;
    localparam logic [3:0] SEL_SLTU   = 4'd4;
    localparam logic [3:0] SEL_XOR    = 4'd5;
    localparam logic [3:0] SEL_SRL    = 4'd6;
    localparam logic [3:0] SEL_SRA    = 4'd7;
    localparam logic [3:0] SEL_OR     = 4'd8;
    localparam logic [3:0] SEL_AND    = 4'd9;
    localparam logic [3:0] SEL_PASS_B = 4'd10;

    // Major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded bundle, also the layout of the output register
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      sel;
        logic [4:0]      rd;
        logic            we;
        logic            ill;
    } dec_t;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    // Immediates: I-type sign-extended, shift amount, U-type upper
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_u;

    assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign imm_u  = {in_instr[31:12], 12'b0};

    logic [NREGS-1:0][XLEN-1:0] rf;
    logic [XLEN-1:0]            rs1_val;
    logic [XLEN-1:0]            rs2_val;
    logic                       wb_hit;
    dec_t                       dec;
    dec_t                       held;
    logic                       legal;
    logic                       out_vld_q;
    logic                       accept;

    // A real writeback never targets x0; x0 stays zero regardless
    assign wb_hit = wb_en && (wb_rd != 5'd0);

    // Handshake: the single output register can take a new entry when empty
    // or when it is being drained this cycle.  Flush swallows the input.
    assign in_ready = !out_vld_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Register-file write port; cleared on reset, x0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf <= '0;
        end else if (wb_hit) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Combinational operand read with optional same-cycle writeback forwarding
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = rf[rs1];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_hit && (wb_rd == rs1)) rs1_val = wb_data;
`endif
        end
        if (rs2 != 5'd0) begin
            rs2_val = rf[rs2];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_hit && (wb_rd == rs2)) rs2_val = wb_data;
`endif
        end
    end

    // Instruction decode: operand selection, ALU op and legality
    always_comb begin
        dec    = '0;
        dec.rd = rd;
        legal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.a = rs1_val;
                dec.b = rs2_val;
                case (funct3)
                    3'b000:  dec.sel = funct7[5] ? SEL_SUB : SEL_ADD;
                    3'b001:  dec.sel = SEL_SLL;
                    3'b010:  dec.sel = SEL_SLT;
                    3'b011:  dec.sel = SEL_SLTU;
                    3'b100:  dec.sel = SEL_XOR;
                    3'b101:  dec.sel = funct7[5] ? SEL_SRA : SEL_SRL;
                    3'b110:  dec.sel = SEL_OR;
                    default: dec.sel = SEL_AND;
                endcase
                // Only SUB and SRA may use the alternate funct7
                if (funct7 == F7_ALT)
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                else
                    legal = (funct7 == F7_BASE);
            end
            OPC_OP_IMM: begin
                dec.a = rs1_val;
                dec.b = imm_i;
                case (funct3)
                    3'b000:  dec.sel = SEL_ADD;
                    3'b001: begin
                        dec.sel = SEL_SLL;
                        dec.b   = imm_sh;
                        legal   = (funct7 == F7_BASE);
                    end
                    3'b010:  dec.sel = SEL_SLT;
                    3'b011:  dec.sel = SEL_SLTU;
                    3'b100:  dec.sel = SEL_XOR;
                    3'b101: begin
                        dec.sel = funct7[5] ? SEL_SRA : SEL_SRL;
                        dec.b   = imm_sh;
                        legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110:  dec.sel = SEL_OR;
                    default: dec.sel = SEL_AND;
                endcase
            end
            OPC_LUI: begin
                dec.a   = '0;
                dec.b   = imm_u;
                dec.sel = SEL_PASS_B;
            end
            OPC_AUIPC: begin
                dec.a   = in_pc;
                dec.b   = imm_u;
                dec.sel = SEL_ADD;
            end
            default: legal = 1'b0;
        endcase
        // Anything undecodable presents a harmless zero ADD with no writeback
        if (!legal) begin
            dec.a   = '0;
            dec.b   = '0;
            dec.sel = SEL_ADD;
        end
        dec.ill = !legal;
        dec.we  = legal && (rd != 5'd0);
    end

    // Output register: flush wins, then accept, then drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            held      <= '0;
        end else begin
            if (flush)
                out_vld_q <= 1'b0;
            else if (accept)
                out_vld_q <= 1'b1;
            else if (out_ready)
                out_vld_q <= 1'b0;
            if (accept) held <= dec;
        end
    end

    assign out_valid   = out_vld_q;
    assign out_A       = held.a;
    assign out_B       = held.b;
    assign out_ALUSel  = held.sel;
    assign out_rd      = held.rd;
    assign out_we      = held.we;
    assign out_illegal = held.ill;

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Pipeline stage directly upstream of the 32-bit ALU.
- Accepts one RV32I instruction per handshake, decodes it, reads operands from an internal 32x32 register file, and presents registered A, B and ALUSel to the ALU.
- Also accepts the writeback port that updates the register file.
- Single output register with valid/ready handshake; supports stall and flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction offered
- in_ready  output  1  stage can accept an instruction
- in_instr  input  32  RV32I instruction word
- in_pc  input  32  PC of in_instr
- flush  input  1  discard the held output and the current input
- wb_en  input  1  register-file write enable
- wb_rd  input  5  write address
- wb_data  input  32  write data
- out_valid  output  1  operands valid for the ALU
- out_ready  input  1  downstream accepts
- out_A  output  32  ALU operand A
- out_B  output  32  ALU operand B
- out_ALUSel  output  4  ALU operation select
- out_rd  output  5  destination register
- out_we  output  1  result must be written back
- out_illegal  output  1  instruction not decodable

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_A=0, out_B=0, out_ALUSel=0, out_rd=0, out_we=0, out_illegal=0. All register-file entries are cleared to 0.
- Reset asserted mid-operation drops any held instruction immediately, with no partial output.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs when in_valid && in_ready; the output registers load at that clock edge.
  - Latency is 1 cycle from accept to out_valid.
  - Output fields are held stable while out_valid && !out_ready.
  - When out_valid && out_ready && !in_valid, out_valid clears next cycle.
- Flush:
  - Forces out_valid=0 at the next edge and ignores any input in that cycle, even if in_valid && in_ready.
  - Register-file writes in that cycle still occur.
- ALUSel encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B. Codes 11-15 are never emitted.
- Decode by opcode = in_instr[6:0]:
  - 0110011 (OP):
    - A=rf[rs1], B=rf[rs2].
    - Op taken from funct3, plus funct7[5], which selects SUB/SRA.
    - funct7 other than 0000000 or 0100000 (the latter only with funct3 000 or 101) is illegal.
  - 0010011 (OP-IMM):
    - A=rf[rs1], B=sign-extended I-immediate.
    - For SLLI/SRLI/SRAI, B={27'b0, shamt}. funct7 must be 0000000, or 0100000 for SRAI only; anything else is illegal.
  - 0110111 (LUI): A=0, B={imm[31:12],12'b0}, ALUSel=PASS_B.
  - 0010111 (AUIPC): A=in_pc, B={imm[31:12],12'b0}, ALUSel=ADD.
  - Any other opcode: out_illegal=1, out_we=0, out_A=out_B=0, out_ALUSel=ADD.
- Destination: out_we=1 for legal instructions with rd!=0; otherwise 0. out_rd=in_instr[11:7].
- Register file:
  - Reads are combinational.
  - Writes occur at the clock edge when wb_en && wb_rd!=0. A write to x0 is ignored, and reads of x0 always return 0.
  - Writes proceed regardless of the handshake state or stall.
- Same-cycle write and read of the same register: the behaviour is set by the optional feature.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: when wb_en && wb_rd!=0 && wb_rd equals rs1 or rs2 in the accept cycle, the captured operand is wb_data (write-first).
- Undefined: the captured operand is the pre-write register value (read-first). The downstream hazard logic must then stall.
- With the macro defined or undefined, x0 is never bypassed.

Test Plan:
- Reset: assert rst_n=0 mid-transfer, then release -> out_valid=0, all outputs 0, and reading x5 via ADD x1,x5,x0 gives A=0.
- Write then ADD:
  - Stimulus: wb x1=7, wb x2=5, then ADD x3,x1,x2 (0x002081B3) with out_ready=1.
  - Response: next cycle out_A=7, out_B=5, out_ALUSel=0, out_rd=3, out_we=1.
- Immediates:
  - SRAI x4,x1,3 (0x4030D213) -> B=3, ALUSel=7.
  - ADDI x4,x1,-1 (0xFFF08213) -> B=0xFFFFFFFF.
  - LUI x5,0x12345 (0x123452B7) -> A=0, B=0x12345000, ALUSel=10.
- Backpressure:
  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held constant.
  - Raise out_ready -> next instruction appears 1 cycle later; no instruction lost or duplicated.
- Flush and illegal:
  - flush=1 with out_valid=1 -> out_valid=0 next cycle.
  - Opcode 0000000 -> out_illegal=1, out_we=0.
  - ADD x0,x1,x2 -> out_we=0.
- Bypass:
  - Same cycle as ADD x3,x1,x2, apply wb x1=9 (x1 previously 7).
  - Response: A=9 with DECODE_WB_BYPASS_EN defined, A=7 without it.
